power_decomp_datapath: RTL and testbench

Datapath stage that sits directly under the procesador's control FSM. It decodes the FSM's seven control lines (a1..a7) each cycle and updates the A/E/K registers that the FSM reads back to choose its next state. It decomposes an 8-bit operand into its set powers of two, accumulates them into a result with a term count, and publishes the result on a one-cycle done strobe.

---
 rtl/power_decomp_datapath.sv | 140 ++++++++++++++
 tb/tb_power_decomp_datapath.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/power_decomp_datapath.sv
// Power-of-two decomposition datapath driven by the procesador control FSM (a1..a7).
// Optional per-term trace outputs are enabled with POWER_DECOMP_TRACE_EN.
module power_decomp_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       a4,
  input  logic       a5,
  input  logic       a6,
  input  logic       a7,
  output logic [7:0] A,
  output logic       E,
  output logic [7:0] K,
  output logic [7:0] result,
  output logic [3:0] count,
  output logic       done
`ifdef POWER_DECOMP_TRACE_EN
  ,
  output logic       term_valid,
  output logic [7:0] term_k
`endif
);

  localparam logic [6:0] CodeWait   = 7'b0000001;
  localparam logic [6:0] CodeScale  = 7'b1111111;
  localparam logic [6:0] CodeSelect = 7'b0110111;
  localparam logic [6:0] CodeSub    = 7'b0011111;
  localparam logic [6:0] CodeZero   = 7'b0111101;
  localparam logic [6:0] CodePrint  = 7'b0111110;

  logic [6:0] ctrl;
  logic [7:0] a_q, a_d, k_q, k_d, r_q, r_d, result_q, result_d;
  logic [3:0] c_q, c_d, count_q, count_d;
  logic       e_q, e_d, done_q, done_d;
  logic       ge_k, ge_2k, rec;

  assign ctrl  = {a1, a2, a3, a4, a5, a6, a7};
  assign ge_k  = (a_q >= k_q);
  // 9-bit compare so K=128 never wraps when doubled
  assign ge_2k = ({1'b0, a_q} >= {k_q, 1'b0});
  assign rec   = (ctrl == CodeSelect) && ge_k;

  always_comb begin
    a_d      = a_q;
    k_d      = k_q;
    e_d      = e_q;
    r_d      = r_q;
    c_d      = c_q;
    result_d = result_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (ctrl)
      CodeWait: begin
        a_d = din;
        k_d = 8'd1;
        e_d = 1'b0;
        r_d = 8'd0;
        c_d = 4'd0;
      end
      CodeScale: begin
        if (ge_2k) k_d = {k_q[6:0], 1'b0};
      end
      CodeSelect: begin
        if (ge_k) begin
          r_d = r_q | k_q;
          c_d = c_q + 4'd1;
        end
        // E must be settled before SUBTRACT, where the FSM branches on it
        e_d = (a_q != k_q);
      end
      CodeSub: begin
        if (ge_k) a_d = a_q - k_q;
        k_d = 8'd1;
      end
      CodeZero: begin
        k_d = 8'd1;
      end
      CodePrint: begin
        result_d = r_q;
        count_d  = c_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= 8'd0;
      k_q      <= 8'd1;
      e_q      <= 1'b0;
      r_q      <= 8'd0;
      c_q      <= 4'd0;
      result_q <= 8'd0;
      count_q  <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      k_q      <= k_d;
      e_q      <= e_d;
      r_q      <= r_d;
      c_q      <= c_d;
      result_q <= result_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  assign A      = a_q;
  assign E      = e_q;
  assign K      = k_q;
  assign result = result_q;
  assign count  = count_q;
  assign done   = done_q;

`ifdef POWER_DECOMP_TRACE_EN
  logic       tv_q;
  logic [7:0] tk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q <= 1'b0;
      tk_q <= 8'd0;
    end else begin
      tv_q <= rec;
      if (rec) tk_q <= k_q;
    end
  end

  assign term_valid = tv_q;
  assign term_k     = tk_q;
`else
  logic unused_rec;
  assign unused_rec = rec;
`endif

endmodule

// File: tb/tb_power_decomp_datapath.sv
// Directed self-checking bench for power_decomp_datapath.
module tb_power_decomp_datapath;

  localparam logic [6:0] CWait   = 7'b0000001;
  localparam logic [6:0] CScale  = 7'b1111111;
  localparam logic [6:0] CSelect = 7'b0110111;
  localparam logic [6:0] CSub    = 7'b0011111;
  localparam logic [6:0] CZero   = 7'b0111101;
  localparam logic [6:0] CPrint  = 7'b0111110;
  localparam logic [6:0] CIll    = 7'b1010101;
  localparam logic [6:0] CIdle   = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [6:0] ctrl;
  logic [7:0] A, K, result;
  logic       E, done;
  logic [3:0] count;
`ifdef POWER_DECOMP_TRACE_EN
  logic       term_valid;
  logic [7:0] term_k;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  power_decomp_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .a1         (ctrl[6]),
    .a2         (ctrl[5]),
    .a3         (ctrl[4]),
    .a4         (ctrl[3]),
    .a5         (ctrl[2]),
    .a6         (ctrl[1]),
    .a7         (ctrl[0]),
    .A          (A),
    .E          (E),
    .K          (K),
    .result     (result),
    .count      (count),
    .done       (done)
`ifdef POWER_DECOMP_TRACE_EN
    ,
    .term_valid (term_valid),
    .term_k     (term_k)
`endif
  );

  task automatic step(input logic [6:0] code);
    ctrl = code;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 8'd0;
    ctrl  = CIdle;
    step(CIdle);
    step(CIdle);
    chk("rst_A", A, 8'h00);
    chk("rst_K", K, 8'h01);
    chk("rst_E", {7'd0, E}, 8'h00);
    chk("rst_result", result, 8'h00);
    chk("rst_count", {4'd0, count}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    reset = 1'b0;

    // reset in the middle of SCALE with K=4
    din = 8'd12;
    step(CWait);
    step(CScale);
    step(CScale);
    chk("mid_K4", K, 8'h04);
    reset = 1'b1;
    step(CScale);
    reset = 1'b0;
    chk("mid_rst_A", A, 8'h00);
    chk("mid_rst_K", K, 8'h01);
    chk("mid_rst_E", {7'd0, E}, 8'h00);
    chk("mid_rst_done", {7'd0, done}, 8'h00);
    din = 8'd9;
    step(CWait);
    chk("reload_A", A, 8'h09);

    // operand 0
    din = 8'd0;
    step(CWait);
    step(CScale);
    chk("z_K", K, 8'h01);
    step(CSelect);
    step(CPrint);
    chk("z_result", result, 8'h00);
    chk("z_count", {4'd0, count}, 8'h00);
    chk("z_done", {7'd0, done}, 8'h01);
    step(CIdle);
    chk("z_done_low", {7'd0, done}, 8'h00);

    // operand 5 with an illegal code held mid-operation
    din = 8'd5;
    step(CWait);
    chk("f_A", A, 8'h05);
    step(CScale);
    chk("f_K2", K, 8'h02);
    step(CScale);
    chk("f_K4a", K, 8'h04);
    step(CScale);
    chk("f_K4b", K, 8'h04);
    step(CSelect);
    chk("f_E1", {7'd0, E}, 8'h01);
`ifdef POWER_DECOMP_TRACE_EN
    chk("f_tv1", {7'd0, term_valid}, 8'h01);
    chk("f_tk1", term_k, 8'h04);
`endif
    for (int i = 0; i < 3; i++) begin
      step(CIll);
      chk("ill_A", A, 8'h05);
      chk("ill_K", K, 8'h04);
      chk("ill_E", {7'd0, E}, 8'h01);
      chk("ill_done", {7'd0, done}, 8'h00);
    end
    step(CSub);
    chk("f_sub_A", A, 8'h01);
    chk("f_sub_K", K, 8'h01);
    chk("f_sub_E", {7'd0, E}, 8'h01);
`ifdef POWER_DECOMP_TRACE_EN
    chk("f_tv0", {7'd0, term_valid}, 8'h00);
`endif
    step(CScale);
    chk("f_K1", K, 8'h01);
    step(CSelect);
    chk("f_E0", {7'd0, E}, 8'h00);
`ifdef POWER_DECOMP_TRACE_EN
    chk("f_tv2", {7'd0, term_valid}, 8'h01);
    chk("f_tk2", term_k, 8'h01);
`endif
    chk("f_hold_result", result, 8'h00);
    step(CPrint);
    chk("f_result", result, 8'h05);
    chk("f_count", {4'd0, count}, 8'h02);
    chk("f_done", {7'd0, done}, 8'h01);
    step(CIdle);
    chk("f_done_low", {7'd0, done}, 8'h00);
    chk("f_result_hold", result, 8'h05);

    // operand 4: exact power, goes through ZERO
    din = 8'd4;
    step(CWait);
    step(CScale);
    step(CScale);
    step(CScale);
    chk("p4_K", K, 8'h04);
    step(CSelect);
    chk("p4_E", {7'd0, E}, 8'h00);
    step(CSub);
    chk("p4_A0", A, 8'h00);
    step(CZero);
    chk("p4_zero_K", K, 8'h01);
    step(CScale);
    step(CSelect);
    step(CPrint);
    chk("p4_result", result, 8'h04);
    chk("p4_count", {4'd0, count}, 8'h01);
    chk("p4_A", A, 8'h00);
    chk("p4_done", {7'd0, done}, 8'h01);

    // operand 0xFF: K reaches 128 without wrapping, eight terms
    din = 8'hFF;
    step(CWait);
    for (int t = 0; t < 8; t++) begin
      for (int s = 0; s < 8; s++) step(CScale);
      if (t == 0) chk("ff_K128", K, 8'h80);
      step(CSelect);
      step(CSub);
    end
    chk("ff_A", A, 8'h00);
    step(CPrint);
    chk("ff_result", result, 8'hFF);
    chk("ff_count", {4'd0, count}, 8'h08);
    chk("ff_done", {7'd0, done}, 8'h01);
    step(CIdle);
    chk("ff_done_low", {7'd0, done}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
